// File: rtl/solver_ctrl.sv
// -----------------------------------------------------------------------------
// solver_ctrl
//
// Sequencing controller in front of the Encryptor, Decryptor and Password_Gen
// engines. It accepts one work request at a time (valid/ready) and decodes the
// 2-bit work code:
//   00 encrypt, 01 decrypt, 10 password gen, 11 reserved (error response)
// It fires a single-cycle start to the selected engine and waits for that
// engine's done pulse, bounded by TIMEOUT_CYCLES. The result (zero-extended to
// 96 bits) or an error is then offered on a valid/ready response interface.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles allowed before aborting with an error (>=2)
//   TMR_W          : WAIT timer width, must be able to hold TIMEOUT_CYCLES
//
// Ports
//   Clk, Rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_work, req_data request payload
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_err response payload
//   enc/dec/pg_start      one-cycle engine start pulses
//   enc_data, dec_data    operands held stable from accept to the next accept
//   enc/dec/pg_done       engine completion pulses
//   enc/dec/pg_result     engine results
//   busy                  high whenever the controller is not idle
//
// Optional build macro
//   SOLVER_CTRL_STATS_EN  adds ok_count[15:0] / err_count[15:0]: saturating
//                         counts of successful and error response handshakes.
// -----------------------------------------------------------------------------
module solver_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 11
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_work,
  input  logic [95:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [95:0] rsp_data,
  output logic        rsp_err,
  output logic        enc_start,
  output logic        dec_start,
  output logic        pg_start,
  output logic [79:0] enc_data,
  output logic [95:0] dec_data,
  input  logic        enc_done,
  input  logic        dec_done,
  input  logic        pg_done,
  input  logic [95:0] enc_result,
  input  logic [79:0] dec_result,
  input  logic [79:0] pg_result,
`ifdef SOLVER_CTRL_STATS_EN
  output logic [15:0] ok_count,
  output logic [15:0] err_count,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0]       WORK_ENC  = 2'b00;
  localparam logic [1:0]       WORK_DEC  = 2'b01;
  localparam logic [1:0]       WORK_PG   = 2'b10;
  localparam logic [1:0]       WORK_RSVD = 2'b11;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       work_q, work_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [79:0]      enc_data_q, enc_data_d;
  logic [95:0]      dec_data_q, dec_data_d;
  logic [95:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  // Done/result of the engine picked by the latched work code. Done pulses
  // from the other engines never reach the FSM.
  logic             sel_done;
  logic [95:0]      sel_result;

  logic             rsp_fire;

  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    case (work_q)
      WORK_ENC: begin
        sel_done   = enc_done;
        sel_result = enc_result;
      end
      WORK_DEC: begin
        sel_done   = dec_done;
        sel_result = {16'h0000, dec_result};
      end
      WORK_PG: begin
        sel_done   = pg_done;
        sel_result = {16'h0000, pg_result};
      end
      default: begin
        sel_done   = 1'b0;
        sel_result = '0;
      end
    endcase
  end

  assign rsp_fire = (state_q == S_RESP) && rsp_ready;

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    timer_d    = timer_q;
    enc_data_d = enc_data_q;
    dec_data_d = dec_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    enc_start  = 1'b0;
    dec_start  = 1'b0;
    pg_start   = 1'b0;
    busy       = 1'b1;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          work_d     = req_work;
          enc_data_d = req_data[79:0];
          dec_data_d = req_data;
          if (req_work == WORK_RSVD) begin
            // Reserved code skips the engines entirely.
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        enc_start = (work_q == WORK_ENC);
        dec_start = (work_q == WORK_DEC);
        pg_start  = (work_q == WORK_PG);
        timer_d   = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // Done is checked before the timeout so a completion on the last
        // allowed cycle still counts as a success.
        if (sel_done) begin
          rsp_data_d = sel_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      timer_q    <= '0;
      enc_data_q <= '0;
      dec_data_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      timer_q    <= timer_d;
      enc_data_q <= enc_data_d;
      dec_data_q <= dec_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign enc_data = enc_data_q;
  assign dec_data = dec_data_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

`ifdef SOLVER_CTRL_STATS_EN
  logic [15:0] ok_count_q, ok_count_d;
  logic [15:0] err_count_q, err_count_d;

  // Counters advance only on the response handshake and stick at all-ones.
  always_comb begin
    ok_count_d  = ok_count_q;
    err_count_d = err_count_q;
    if (rsp_fire) begin
      if (rsp_err_q) begin
        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      end else begin
        if (ok_count_q != 16'hFFFF) ok_count_d = ok_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ok_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      ok_count_q  <= ok_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign ok_count  = ok_count_q;
  assign err_count = err_count_q;
`else
  // Without statistics the handshake strobe has no consumer.
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule
